// File: rtl/tl_pkg.sv
// Shared definitions for the traffic light controller and its monitor:
// light codes, fault causes, monitor states and the legal successor rule.
package tl_pkg;

    // Light code as carried on the 2-bit controller-to-monitor interface
    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    // The one encoding that never names a lamp
    localparam logic [1:0] CODE_ILLEGAL = 2'b11;

    // Fault causes, recorded in fault_code (first cause wins)
    localparam logic [1:0] FLT_NONE  = 2'b00;
    localparam logic [1:0] FLT_CODE  = 2'b01;
    localparam logic [1:0] FLT_TRANS = 2'b10;
    localparam logic [1:0] FLT_DWELL = 2'b11;

    // Monitor operating states
    typedef enum logic [1:0] {
        INIT  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } mon_state_t;

    // Only legal change from a held code: G->Y, Y->R, R->G
    function automatic logic [1:0] next_light(input logic [1:0] code);
        logic [1:0] nxt;
        case (code)
            GREEN:   nxt = YELLOW;
            YELLOW:  nxt = RED;
            RED:     nxt = GREEN;
            default: nxt = RED;
        endcase
        return nxt;
    endfunction

    // One-hot lamp drive {g, y, r} for a code; anything unknown shows red
    function automatic logic [2:0] lamps_of(input logic [1:0] code);
        logic [2:0] lamps;
        case (code)
            GREEN:   lamps = 3'b100;
            YELLOW:  lamps = 3'b010;
            default: lamps = 3'b001;
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// Counts valid samples for which the current light code has been held and
// flags a change that comes too early (short) or a hold that would run past
// the maximum (stuck).
module tl_dwell_counter #(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 16,
    parameter int W         = $clog2(MAX_DWELL + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         short_dwell,
    output logic         stuck
);

    localparam logic [W-1:0] MIN_W = W'(MIN_DWELL);
    localparam logic [W-1:0] MAX_W = W'(MAX_DWELL);

    logic [W-1:0] count_reg;

    // Clear has priority over load (new code seen once) over increment (hold)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= W'(1);
        end else if (inc && (count_reg != MAX_W)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count       = count_reg;
    assign short_dwell = (count_reg < MIN_W);
    assign stuck       = (count_reg == MAX_W);

endmodule

// File: rtl/traffic_light_monitor.sv
// Receiver for the controller's light code: registers and decodes it to lamp
// drives, checks code legality, sequence and dwell, and on the first problem
// latches a sticky fault with all-red lamps until software clears it.
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       light_in,
    input  logic             light_valid,
    input  logic             fault_clr,
    output logic             lamp_g,
    output logic             lamp_y,
    output logic             lamp_r,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int DW = $clog2(MAX_DWELL + 1);

    mon_state_t     state_reg;
    logic [1:0]     light_q_reg;
    logic [1:0]     cause_next;
    logic           enter_fault;
    logic           cnt_clear;
    logic           cnt_load;
    logic           cnt_inc;
    logic [DW-1:0]  dwell_count;
    logic           dwell_short;
    logic           dwell_stuck;

    tl_dwell_counter #(
        .MIN_DWELL (MIN_DWELL),
        .MAX_DWELL (MAX_DWELL),
        .W         (DW)
    ) u_dwell (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (cnt_clear),
        .load        (cnt_load),
        .inc         (cnt_inc),
        .count       (dwell_count),
        .short_dwell (dwell_short),
        .stuck       (dwell_stuck)
    );

    // Classify the current sample: violation cause (highest priority only)
    // and what the dwell counter should do with it
    always_comb begin
        cause_next = FLT_NONE;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        case (state_reg)
            INIT: begin
                if (light_valid) begin
                    if (light_in == CODE_ILLEGAL) begin
                        cause_next = FLT_CODE;
                    end else begin
                        cnt_load = 1'b1;
                    end
                end
            end
            RUN: begin
                if (light_valid) begin
                    if (light_in == CODE_ILLEGAL) begin
                        cause_next = FLT_CODE;
                    end else if (light_in != light_q_reg) begin
                        if (light_in != next_light(light_q_reg)) begin
                            cause_next = FLT_TRANS;
                        end else if (dwell_short) begin
                            cause_next = FLT_DWELL;
                        end else begin
                            cnt_load = 1'b1;
                        end
                    end else if (dwell_stuck) begin
                        cause_next = FLT_DWELL;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            FAULT: begin
                cnt_clear = fault_clr;
            end
            default: begin
                cnt_clear = 1'b1;
            end
        endcase
        // Counter restarts from zero whenever the monitor drops into FAULT
        if (cause_next != FLT_NONE) begin
            cnt_clear = 1'b1;
        end
    end

    assign enter_fault = (cause_next != FLT_NONE);

    // Monitor FSM with registered lamp, fault and error-count outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= INIT;
            light_q_reg <= GREEN;
            lamp_g      <= 1'b0;
            lamp_y      <= 1'b0;
            lamp_r      <= 1'b1;
            fault       <= 1'b0;
            fault_code  <= FLT_NONE;
            err_cnt     <= '0;
        end else if (enter_fault) begin
            state_reg  <= FAULT;
            lamp_g     <= 1'b0;
            lamp_y     <= 1'b0;
            lamp_r     <= 1'b1;
            fault      <= 1'b1;
            fault_code <= cause_next;
            if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end else begin
            case (state_reg)
                INIT, RUN: begin
                    // Legal first sample, change or hold: show the code
                    if (light_valid) begin
                        state_reg                <= RUN;
                        light_q_reg              <= light_in;
                        {lamp_g, lamp_y, lamp_r} <= lamps_of(light_in);
                    end
                end
                FAULT: begin
                    // Clear wins over any sample arriving in the same cycle
                    if (fault_clr) begin
                        state_reg  <= INIT;
                        lamp_g     <= 1'b0;
                        lamp_y     <= 1'b0;
                        lamp_r     <= 1'b1;
                        fault      <= 1'b0;
                        fault_code <= FLT_NONE;
                    end
                end
                default: begin
                    state_reg <= FAULT;
                    lamp_g    <= 1'b0;
                    lamp_y    <= 1'b0;
                    lamp_r    <= 1'b1;
                    fault     <= 1'b1;
                end
            endcase
        end
    end

    // The hold counter saturates at MAX_DWELL; a larger value means a broken counter
    always @(posedge clk) begin
        if (reset_n) begin
            assert (dwell_count <= DW'(MAX_DWELL))
                else $error("dwell count %0d above maximum", dwell_count);
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: two instances (MIN/MAX 1/4 and 3/6) share
// stimulus; a directed vector table, hand sequences and random traffic are
// checked against a reference model of the monitoring rules.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] light_in = 2'b00;
    logic       light_valid = 1'b0;
    logic       fault_clr = 1'b0;

    logic       lamp_g_a, lamp_y_a, lamp_r_a, fault_a;
    logic [1:0] fault_code_a;
    logic [7:0] err_cnt_a;
    logic       lamp_g_b, lamp_y_b, lamp_r_b, fault_b;
    logic [1:0] fault_code_b;
    logic [7:0] err_cnt_b;

    always #5 clk = ~clk;

    traffic_light_monitor #(.MIN_DWELL(1), .MAX_DWELL(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .light_in(light_in),
        .light_valid(light_valid), .fault_clr(fault_clr),
        .lamp_g(lamp_g_a), .lamp_y(lamp_y_a), .lamp_r(lamp_r_a),
        .fault(fault_a), .fault_code(fault_code_a), .err_cnt(err_cnt_a)
    );

    traffic_light_monitor #(.MIN_DWELL(3), .MAX_DWELL(6), .CNT_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .light_in(light_in),
        .light_valid(light_valid), .fault_clr(fault_clr),
        .lamp_g(lamp_g_b), .lamp_y(lamp_y_b), .lamp_r(lamp_r_b),
        .fault(fault_b), .fault_code(fault_code_b), .err_cnt(err_cnt_b)
    );

    int checks = 0;
    int failures = 0;
    int tx = 0;

    // Reference model state per instance: what has been seen, not how the RTL stores it
    int min_d[2] = '{1, 3};
    int max_d[2] = '{4, 6};
    bit has_prev[2];
    int prev[2];
    int run_len[2];
    bit faulted[2];
    int cause[2];
    int errs[2];

    // Packed view {g, y, r, fault, fault_code[1:0], err_cnt[7:0]}
    function automatic logic [13:0] pk(bit g, bit y, bit r, bit f, int fc, int err);
        return {g, y, r, f, 2'(fc), 8'(err)};
    endfunction

    function automatic logic [13:0] actual(int m);
        if (m == 0)
            return {lamp_g_a, lamp_y_a, lamp_r_a, fault_a, fault_code_a, err_cnt_a};
        return {lamp_g_b, lamp_y_b, lamp_r_b, fault_b, fault_code_b, err_cnt_b};
    endfunction

    function automatic logic [13:0] expected(int m);
        bit g, y, r;
        g = 1'b0; y = 1'b0; r = 1'b1;
        if (!faulted[m] && has_prev[m]) begin
            g = (prev[m] == 0);
            y = (prev[m] == 1);
            r = (prev[m] == 2);
        end
        return pk(g, y, r, faulted[m], cause[m], errs[m]);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            has_prev[m] = 1'b0; prev[m] = 0; run_len[m] = 0;
            faulted[m] = 1'b0; cause[m] = 0; errs[m] = 0;
        end
    endtask

    // Apply the monitoring rules to the inputs present at this clock edge
    task automatic model_step(int m, bit v, int code, bit clr);
        int c;
        if (faulted[m]) begin
            if (clr) begin
                faulted[m] = 1'b0; cause[m] = 0; has_prev[m] = 1'b0; run_len[m] = 0;
            end
            return;
        end
        if (!v) return;
        c = 0;
        if (code == 3)
            c = 1;
        else if (has_prev[m] && code != prev[m] && code != (prev[m] + 1) % 3)
            c = 2;
        else if (has_prev[m] && code != prev[m] && run_len[m] < min_d[m])
            c = 3;
        else if (has_prev[m] && code == prev[m] && run_len[m] + 1 > max_d[m])
            c = 3;
        if (c != 0) begin
            faulted[m] = 1'b1;
            cause[m] = c;
            if (errs[m] < 255) errs[m]++;
        end else begin
            run_len[m] = (has_prev[m] && code == prev[m]) ? run_len[m] + 1 : 1;
            prev[m] = code;
            has_prev[m] = 1'b1;
        end
    endtask

    task automatic check(string name, int m, logic [13:0] want);
        logic [13:0] got;
        got = actual(m);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s dut%0d got gyr_f_fc_err=%b_%b_%b_%0d required=%b_%b_%b_%0d",
                     name, m, got[13:11], got[10], got[9:8], got[7:0],
                     want[13:11], want[10], want[9:8], want[7:0]);
        end
    endtask

    // One clock of stimulus: drive, let the edge happen, update model, compare both
    task automatic cycle(bit v, logic [1:0] code, bit clr);
        light_valid = v;
        light_in    = code;
        fault_clr   = clr;
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_step(m, v, int'(code), clr);
        #1;
        check("model", 0, expected(0));
        check("model", 1, expected(1));
        tx++;
        $display("tx %0d v=%b code=%b clr=%b a=%h b=%h", tx, v, code, clr, actual(0), actual(1));
    endtask

    task automatic do_reset();
        light_valid = 1'b0; light_in = 2'b00; fault_clr = 1'b0;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("reset_state", 0, pk(0, 0, 1, 0, 0, 0));
        check("reset_state", 1, pk(0, 0, 1, 0, 0, 0));
        reset_n = 1'b1;
        #2;
    endtask

    typedef struct {
        bit         v;
        logic [1:0] code;
        bit         clr;
        logic [13:0] exp_a;
    } vec_t;

    vec_t vecs[16];
    logic [1:0] cur;
    bit rv, rc;
    int r;

    initial begin
        // Directed table, expectations worked out by hand for MIN=1, MAX=4
        vecs[0]  = '{1'b1, 2'b00, 1'b0, pk(1, 0, 0, 0, 0, 0)};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, pk(0, 1, 0, 0, 0, 0)};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, pk(0, 0, 1, 0, 0, 0)};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, pk(1, 0, 0, 0, 0, 0)};
        vecs[4]  = '{1'b1, 2'b01, 1'b0, pk(0, 1, 0, 0, 0, 0)};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, pk(0, 1, 0, 0, 0, 0)};
        vecs[6]  = '{1'b1, 2'b10, 1'b0, pk(0, 0, 1, 0, 0, 0)};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, pk(1, 0, 0, 0, 0, 0)};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, pk(0, 0, 1, 1, 2, 1)};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, pk(0, 0, 1, 1, 2, 1)};
        vecs[10] = '{1'b1, 2'b11, 1'b0, pk(0, 0, 1, 1, 2, 1)};
        vecs[11] = '{1'b0, 2'b00, 1'b1, pk(0, 0, 1, 0, 0, 1)};
        vecs[12] = '{1'b1, 2'b11, 1'b0, pk(0, 0, 1, 1, 1, 2)};
        vecs[13] = '{1'b1, 2'b00, 1'b1, pk(0, 0, 1, 0, 0, 2)};
        vecs[14] = '{1'b1, 2'b10, 1'b0, pk(0, 0, 1, 0, 0, 2)};
        vecs[15] = '{1'b0, 2'b10, 1'b0, pk(0, 0, 1, 0, 0, 2)};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].v, vecs[i].code, vecs[i].clr);
            check("table", 0, vecs[i].exp_a);
        end

        // Stuck: four holds of GREEN are fine, the fifth faults (MAX=4)
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'b00, 1'b0);
            check("hold_ok", 0, pk(1, 0, 0, 0, 0, 0));
        end
        cycle(1'b1, 2'b00, 1'b0);
        check("stuck", 0, pk(0, 0, 1, 1, 3, 1));
        cycle(1'b0, 2'b00, 1'b1);
        check("clear", 0, pk(0, 0, 1, 0, 0, 1));
        // Same hold with idle cycles between samples
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'b00, 1'b0);
            cycle(1'b0, 2'b00, 1'b0);
            check("hold_gapped_ok", 0, pk(1, 0, 0, 0, 0, 1));
        end
        cycle(1'b1, 2'b00, 1'b0);
        check("stuck_gapped", 0, pk(0, 0, 1, 1, 3, 2));

        // Short dwell: GREEN once then YELLOW faults only the MIN=3 instance
        do_reset();
        cycle(1'b1, 2'b00, 1'b0);
        cycle(1'b1, 2'b01, 1'b0);
        check("short_dwell", 1, pk(0, 0, 1, 1, 3, 1));
        check("short_ok_min1", 0, pk(0, 1, 0, 0, 0, 0));

        // Error counter saturation over 300 violation/clear rounds
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 2'b11, 1'b0);
            cycle(1'b0, 2'b00, 1'b1);
        end
        check("err_saturate", 0, pk(0, 0, 1, 0, 0, 255));
        check("err_saturate", 1, pk(0, 0, 1, 0, 0, 255));

        // Asynchronous reset in the middle of FAULT with clear and valid high
        cycle(1'b1, 2'b11, 1'b0);
        check("fault_before_reset", 0, pk(0, 0, 1, 1, 1, 255));
        light_valid = 1'b1; fault_clr = 1'b1; light_in = 2'b01;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", 0, pk(0, 0, 1, 0, 0, 0));
        check("async_reset", 1, pk(0, 0, 1, 0, 0, 0));
        do_reset();

        // Random traffic biased toward legal holds and changes
        cur = 2'b00;
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       cur = cur;
            else if (r < 8)  cur = 2'((int'(cur) + 1) % 3);
            else if (r == 8) cur = 2'($urandom_range(0, 3));
            else             cur = 2'($urandom_range(0, 2));
            rv = ($urandom_range(0, 9) < 8);
            rc = ($urandom_range(0, 19) == 0);
            cycle(rv, cur, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
